bldcm_deadtime: RTL and testbench



---
 rtl/bldcm_pkg.sv | 31 +++
 rtl/bldcm_deadtime_phase.sv | 81 ++++++++
 rtl/bldcm_deadtime.sv | 99 +++++++++
 tb/tb_bldcm_deadtime.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldcm_pkg.sv
// Shared types and constants for the BLDC gate-drive dead-time stage.
// Command vectors use mask order: bit0=Uh, bit1=Ul, bit2=Vh, bit3=Vl, bit4=Wh, bit5=Wl.
package bldcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H_ON = 2'd1,
    L_ON = 2'd2,
    DEAD = 2'd3
  } phase_state_e;

  // Logical per-phase request, {high, low}
  localparam logic [1:0] REQ_OFF     = 2'b00;
  localparam logic [1:0] REQ_LOW     = 2'b01;
  localparam logic [1:0] REQ_HIGH    = 2'b10;
  localparam logic [1:0] REQ_ILLEGAL = 2'b11;

  localparam int U = 2;
  localparam int V = 1;
  localparam int W = 0;

  localparam int unsigned DEAD_MAX = 65535;

  // Extracts the {high, low} request of one phase from a mask-ordered command vector.
  function automatic logic [1:0] phase_req(input logic [5:0] cmd, input int ph);
    int base;
    base = 2 * (U - ph);
    return {cmd[base], cmd[base+1]};
  endfunction

endpackage

// File: rtl/bldcm_deadtime_phase.sv
// One half-bridge leg: hand-over FSM, dead-time down-counter, shoot-through flag
// and registered gate decode (logical polarity).
module bldcm_deadtime_phase
  import bldcm_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 50,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       force_off,
  input  logic       stat_clr,
  output logic       gate_h,
  output logic       gate_l,
  output logic       shoot
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYCLES - 1);

  phase_state_e     state;
  phase_state_e     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!force_off) begin
          case (req)
            REQ_HIGH:             state_nxt = H_ON;
            REQ_LOW:              state_nxt = L_ON;
            REQ_OFF, REQ_ILLEGAL: state_nxt = IDLE;
            default:              state_nxt = IDLE;
          endcase
        end
      end
      H_ON: begin
        if (force_off || req != REQ_HIGH) begin
          state_nxt = DEAD;
          cnt_nxt   = RELOAD;
        end
      end
      L_ON: begin
        if (force_off || req != REQ_LOW) begin
          state_nxt = DEAD;
          cnt_nxt   = RELOAD;
        end
      end
      DEAD: begin
        // A running dead window always completes, fault or not
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
      shoot  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      gate_h <= (state_nxt == H_ON);
      gate_l <= (state_nxt == L_ON);
      // Capturing a shoot-through request wins over a simultaneous clear
      if (req == REQ_ILLEGAL) shoot <= 1'b1;
      else if (stat_clr)      shoot <= 1'b0;
    end
  end

endmodule

// File: rtl/bldcm_deadtime.sv
// Dead-time gate conditioning for a three-phase BLDC bridge.
// Optional macro BLDCM_DEADTIME_FAULT_LATCH_EN makes the fault force-off sticky until iStatClr.
module bldcm_deadtime
  import bldcm_pkg::*;
#(
  parameter int unsigned pDeadCycles = 50,
  // Masks use bit0=Uh ... bit5=Wl; the default inverts the three low-side commands
  parameter logic [5:0]  pInvertIn   = 6'b101010,
  parameter logic [5:0]  pInvertOut  = 6'b000000
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iUh,
  input  logic       iUl,
  input  logic       iVh,
  input  logic       iVl,
  input  logic       iWh,
  input  logic       iWl,
  input  logic       iFault,
  input  logic       iStatClr,
  output logic       oUh,
  output logic       oUl,
  output logic       oVh,
  output logic       oVl,
  output logic       oWh,
  output logic       oWl,
  output logic [2:0] oShootStat,
  output logic       oFaultActive
);

  localparam int unsigned CNT_W = (pDeadCycles < 1) ? 1 : $clog2(pDeadCycles + 1);

  if (pDeadCycles < 1 || pDeadCycles > DEAD_MAX) begin : g_bad_dead_cycles
    $error("bldcm_deadtime: pDeadCycles must lie in 1..65535");
  end

  logic [5:0] raw_cmd;
  logic [5:0] cmd_q;
  logic       fault_q;
  logic       force_off;
  logic [1:0] req    [3];
  logic [2:0] gate_h;
  logic [2:0] gate_l;
  logic [2:0] shoot;

  assign raw_cmd = {iWl, iWh, iVl, iVh, iUl, iUh};

  // Input register holds logical requests; reset value is OFF on every phase
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      cmd_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cmd_q   <= raw_cmd ^ pInvertIn;
      fault_q <= iFault;
    end
  end

`ifdef BLDCM_DEADTIME_FAULT_LATCH_EN
  logic fault_latch;

  // Sets together with the fault register; clears only once the registered fault is gone
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                    fault_latch <= 1'b0;
    else if (iFault)               fault_latch <= 1'b1;
    else if (iStatClr && !fault_q) fault_latch <= 1'b0;
  end

  assign force_off = fault_latch;
`else
  assign force_off = fault_q;
`endif

  assign oFaultActive = force_off;

  for (genvar p = 0; p < 3; p++) begin : g_phase
    assign req[p] = phase_req(cmd_q, p);

    bldcm_deadtime_phase #(
      .DEAD_CYCLES (pDeadCycles),
      .CNT_W       (CNT_W)
    ) u_phase (
      .clk       (iClock),
      .rst       (iReset),
      .req       (req[p]),
      .force_off (force_off),
      .stat_clr  (iStatClr),
      .gate_h    (gate_h[p]),
      .gate_l    (gate_l[p]),
      .shoot     (shoot[p])
    );
  end

  assign {oWl, oWh, oVl, oVh, oUl, oUh} =
    {gate_l[W], gate_h[W], gate_l[V], gate_h[V], gate_l[U], gate_h[U]} ^ pInvertOut;

  assign oShootStat = {shoot[U], shoot[V], shoot[W]};

endmodule

// File: tb/tb_bldcm_deadtime.sv
// Self-checking bench for bldcm_deadtime: directed table, hand-written corner
// sequences and randomized stimulus against a timestamp-based reference model.
module tb_bldcm_deadtime;
  import bldcm_pkg::*;

  localparam int unsigned DEAD    = 50;
  localparam logic [5:0]  INV_IN  = 6'b101010;
  localparam logic [5:0]  INV_OUT = 6'b000000;

`ifdef BLDCM_DEADTIME_FAULT_LATCH_EN
  localparam logic FACT_AFTER = 1'b1;
`else
  localparam logic FACT_AFTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lreq [3];
  logic       fault_in = 1'b0;
  logic       clr_in = 1'b0;
  logic       uh, ul, vh, vl, wh, wl;
  logic       q_uh, q_ul, q_vh, q_vl, q_wh, q_wl;
  logic [2:0] shoot_stat;
  logic       fault_active;

  int n_vec = 0;
  int n_err = 0;

  assign {wl, wh, vl, vh, ul, uh} =
    {lreq[W][0], lreq[W][1], lreq[V][0], lreq[V][1], lreq[U][0], lreq[U][1]} ^ INV_IN;

  bldcm_deadtime #(
    .pDeadCycles (DEAD),
    .pInvertIn   (INV_IN),
    .pInvertOut  (INV_OUT)
  ) dut (
    .iClock       (clk),
    .iReset       (rst),
    .iUh          (uh),
    .iUl          (ul),
    .iVh          (vh),
    .iVl          (vl),
    .iWh          (wh),
    .iWl          (wl),
    .iFault       (fault_in),
    .iStatClr     (clr_in),
    .oUh          (q_uh),
    .oUl          (q_ul),
    .oVh          (q_vh),
    .oVl          (q_vl),
    .oWh          (q_wh),
    .oWl          (q_wl),
    .oShootStat   (shoot_stat),
    .oFaultActive (fault_active)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Logical gate word {Uh,Ul,Vh,Vl,Wh,Wl}
  function automatic logic [5:0] dut_gates();
    logic [5:0] r;
    r = {q_wl, q_wh, q_vl, q_vh, q_ul, q_uh} ^ INV_OUT;
    return {r[0], r[1], r[2], r[3], r[4], r[5]};
  endfunction

  // Reference model: each phase remembers which side conducts and the edge at
  // which it last stopped conducting; a turn-on needs DEAD+1 edges of off time.
  int         m_cur    [3];  // 0 off, 1 high side, 2 low side
  longint     m_off_at [3];
  logic       m_shoot  [3];
  logic [1:0] m_req_q  [3];
  logic       m_fault_q;
  logic       m_fault_act;
  longint     m_edge;

  task automatic model_reset();
    m_edge = 0;
    for (int p = 0; p < 3; p++) begin
      m_cur[p]    = 0;
      m_off_at[p] = -1000000;
      m_shoot[p]  = 1'b0;
      m_req_q[p]  = REQ_OFF;
    end
    m_fault_q   = 1'b0;
    m_fault_act = 1'b0;
  endtask

  task automatic model_edge();
    logic       frc;
    logic [1:0] r;
    frc = m_fault_act;
    m_edge++;
    for (int p = 0; p < 3; p++) begin
      r = m_req_q[p];
      if (m_cur[p] == 1 && (frc || r != REQ_HIGH)) begin
        m_cur[p] = 0;
        m_off_at[p] = m_edge;
      end else if (m_cur[p] == 2 && (frc || r != REQ_LOW)) begin
        m_cur[p] = 0;
        m_off_at[p] = m_edge;
      end else if (m_cur[p] == 0 && !frc && (m_edge - m_off_at[p]) >= longint'(DEAD + 1)) begin
        if (r == REQ_HIGH)     m_cur[p] = 1;
        else if (r == REQ_LOW) m_cur[p] = 2;
      end
      if (r == REQ_ILLEGAL) m_shoot[p] = 1'b1;
      else if (clr_in)      m_shoot[p] = 1'b0;
    end
`ifdef BLDCM_DEADTIME_FAULT_LATCH_EN
    if (fault_in)                   m_fault_act = 1'b1;
    else if (clr_in && !m_fault_q)  m_fault_act = 1'b0;
`else
    m_fault_act = fault_in;
`endif
    m_fault_q = fault_in;
    for (int p = 0; p < 3; p++) m_req_q[p] = lreq[p];
  endtask

  function automatic logic [5:0] model_gates();
    return {m_cur[U] == 1, m_cur[U] == 2, m_cur[V] == 1, m_cur[V] == 2,
            m_cur[W] == 1, m_cur[W] == 2};
  endfunction

  task automatic compare_model(input string tag);
    check({tag, "_gates"}, 16'(dut_gates()), 16'(model_gates()));
    check({tag, "_shoot"}, 16'(shoot_stat), 16'({m_shoot[U], m_shoot[V], m_shoot[W]}));
    check({tag, "_fault"}, 16'(fault_active), 16'(m_fault_act));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_model("async_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [5:0] req;    // logical {Uh,Ul,Vh,Vl,Wh,Wl}
    logic       fault;
    logic       clr;
    logic [5:0] gates;  // expected logical gates after the edge
    logic [2:0] shoot;
    logic       fact;
  } vec_t;

  localparam int N_TBL = 14;
  vec_t tbl [N_TBL];
  int   n;

  initial begin
    tbl[0]  = '{6'b000000, 1'b0, 1'b0, 6'b000000, 3'b000, 1'b0};
    tbl[1]  = '{6'b100000, 1'b0, 1'b0, 6'b000000, 3'b000, 1'b0};
    tbl[2]  = '{6'b100000, 1'b0, 1'b0, 6'b100000, 3'b000, 1'b0};
    tbl[3]  = '{6'b100001, 1'b0, 1'b0, 6'b100000, 3'b000, 1'b0};
    tbl[4]  = '{6'b100001, 1'b0, 1'b0, 6'b100001, 3'b000, 1'b0};
    tbl[5]  = '{6'b101101, 1'b0, 1'b0, 6'b100001, 3'b000, 1'b0};
    tbl[6]  = '{6'b100001, 1'b0, 1'b0, 6'b100001, 3'b010, 1'b0};
    tbl[7]  = '{6'b100001, 1'b0, 1'b1, 6'b100001, 3'b000, 1'b0};
    tbl[8]  = '{6'b101101, 1'b0, 1'b1, 6'b100001, 3'b000, 1'b0};
    tbl[9]  = '{6'b100001, 1'b0, 1'b1, 6'b100001, 3'b010, 1'b0};
    tbl[10] = '{6'b100001, 1'b0, 1'b0, 6'b100001, 3'b010, 1'b0};
    tbl[11] = '{6'b100001, 1'b1, 1'b0, 6'b100001, 3'b010, 1'b1};
    tbl[12] = '{6'b100001, 1'b0, 1'b0, 6'b000000, 3'b010, FACT_AFTER};
    tbl[13] = '{6'b100001, 1'b0, 1'b0, 6'b000000, 3'b010, FACT_AFTER};

    for (int p = 0; p < 3; p++) lreq[p] = REQ_OFF;
    do_reset();
    #1;
    compare_model("reset_release");

    // Directed table, one clock per row
    for (int i = 0; i < N_TBL; i++) begin
      lreq[U]  = tbl[i].req[5:4];
      lreq[V]  = tbl[i].req[3:2];
      lreq[W]  = tbl[i].req[1:0];
      fault_in = tbl[i].fault;
      clr_in   = tbl[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_gates", i), 16'(dut_gates()), 16'(tbl[i].gates));
      check($sformatf("tbl%0d_shoot", i), 16'(shoot_stat), 16'(tbl[i].shoot));
      check($sformatf("tbl%0d_fault", i), 16'(fault_active), 16'(tbl[i].fact));
    end
    fault_in = 1'b0;
    clr_in   = 1'b0;

    // Turn-on latency and direct high-to-low hand-over on U
    for (int p = 0; p < 3; p++) lreq[p] = REQ_OFF;
    do_reset();
    lreq[U] = REQ_HIGH;
    step("seqa");
    check("uh_after_1_edge", 16'(q_uh ^ INV_OUT[0]), 16'd0);
    step("seqa");
    check("uh_after_2_edges", 16'(q_uh ^ INV_OUT[0]), 16'd1);
    repeat (3) step("seqa");
    lreq[U] = REQ_LOW;
    step("seqa");
    step("seqa");
    check("uh_off_after_2_edges", 16'(q_uh ^ INV_OUT[0]), 16'd0);
    n = 0;
    while (n < 200 && (q_ul ^ INV_OUT[1]) == 1'b0) begin
      step("seqa");
      n++;
    end
    check("u_dead_window", 16'(n), 16'(DEAD + 1));

    // Single-cycle fault pulse while W conducts high
    for (int p = 0; p < 3; p++) lreq[p] = REQ_OFF;
    do_reset();
    lreq[W] = REQ_HIGH;
    repeat (4) step("seqb");
    check("wh_on_before_fault", 16'(q_wh ^ INV_OUT[4]), 16'd1);
    fault_in = 1'b1;
    step("seqb");
    check("fault_active_rise", 16'(fault_active), 16'd1);
    check("wh_on_1_edge_after_fault", 16'(q_wh ^ INV_OUT[4]), 16'd1);
    fault_in = 1'b0;
    step("seqb");
    check("wh_forced_off", 16'(q_wh ^ INV_OUT[4]), 16'd0);
`ifdef BLDCM_DEADTIME_FAULT_LATCH_EN
    repeat (100) step("seqb");
    check("wh_held_while_latched", 16'(q_wh ^ INV_OUT[4]), 16'd0);
    check("fault_still_latched", 16'(fault_active), 16'd1);
    clr_in = 1'b1;
    step("seqb");
    clr_in = 1'b0;
    check("fault_latch_cleared", 16'(fault_active), 16'd0);
    n = 0;
    while (n < 10 && (q_wh ^ INV_OUT[4]) == 1'b0) begin
      step("seqb");
      n++;
    end
    check("wh_resume_after_clear", 16'(n), 16'd1);
`else
    step("seqb");
    check("fault_active_one_cycle", 16'(fault_active), 16'd0);
    n = 1;
    while (n < 200 && (q_wh ^ INV_OUT[4]) == 1'b0) begin
      step("seqb");
      n++;
    end
    check("w_fault_dead_window", 16'(n), 16'(DEAD + 1));
`endif

    // Asynchronous reset in the middle of a dead window
    for (int p = 0; p < 3; p++) lreq[p] = REQ_OFF;
    do_reset();
    lreq[U] = REQ_HIGH;
    lreq[W] = REQ_HIGH;
    lreq[V] = REQ_ILLEGAL;
    step("seqc");
    lreq[V] = REQ_OFF;
    repeat (4) step("seqc");
    check("shoot_before_reset", 16'(shoot_stat), 16'b010);
    lreq[W] = REQ_OFF;
    step("seqc");
    step("seqc");
    check("wh_in_dead", 16'(q_wh ^ INV_OUT[4]), 16'd0);
    repeat (29) step("seqc");
    #2;
    rst = 1'b1;
    #1;
    check("gates_off_without_clock", 16'(dut_gates()), 16'd0);
    check("shoot_cleared_by_reset", 16'(shoot_stat), 16'd0);
    check("fault_cleared_by_reset", 16'(fault_active), 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    lreq[W] = REQ_HIGH;
    step("seqc");
    check("wh_off_1_edge_after_reset", 16'(q_wh ^ INV_OUT[4]), 16'd0);
    step("seqc");
    check("wh_on_2_edges_after_reset", 16'(q_wh ^ INV_OUT[4]), 16'd1);

    // Randomized stimulus against the reference model
    for (int p = 0; p < 3; p++) lreq[p] = REQ_OFF;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 3; p++)
        if ($urandom_range(7) == 0) lreq[p] = 2'($urandom_range(3));
      fault_in = ($urandom_range(199) == 0);
      clr_in   = ($urandom_range(15) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
